// File: rtl/five_bit_arith_pkg.sv
// Shared arithmetic definitions for the five-bit adder/subtractor family.
package five_bit_arith_pkg;

   localparam int DEFAULT_WIDTH = 5;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Signed overflow of a two's-complement add (sub=0) or subtract (sub=1),
   // judged from the operand sign bits and the result sign bit.
   function automatic logic overflow(input logic a_msb, input logic b_msb,
                                     input logic d_msb, input logic sub);
      return ((a_msb ^ b_msb) == sub) && (d_msb != a_msb);
   endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/five_bit_serial_subtractor.sv
// Bit-serial two's-complement subtractor, D = A - B, LSB first over WIDTH
// cycles through a single full_adder cell (B inverted, carry-in 1).
// Optional macro FIVE_BIT_ADD_MODE_EN adds a 'sub' input; sub=0 selects add.
//
// state | meaning
// IDLE  | waiting for start; D/Bout/V hold last result
// SHIFT | one operand bit pair per clock through the full adder
module five_bit_serial_subtractor
   import five_bit_arith_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
`ifdef FIVE_BIT_ADD_MODE_EN
   input  logic             sub,
`endif
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] D,
   output logic             Bout,
   output logic             V,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state, next_state;
   logic [WIDTH-1:0] a_sr, b_sr;
   logic [WIDTH-2:0] r_sr;
   logic [WIDTH-1:0] result;
   logic [CW-1:0]    count;
   logic             carry;
   logic             a_msb, b_msb;
   logic             sub_q, sub_in;
   logic             fa_b, fa_s, fa_c;
   logic             last_bit;

`ifdef FIVE_BIT_ADD_MODE_EN
   assign sub_in = sub;

   // Operation mode is latched with the operands so it cannot change mid-op.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sub_q <= 1'b1;
      else if (state == IDLE && start)
         sub_q <= sub_in;
   end
`else
   assign sub_in = 1'b1;
   assign sub_q  = 1'b1;
`endif

   assign fa_b     = b_sr[0] ^ sub_q;
   assign result   = {fa_s, r_sr};
   assign last_bit = (state == SHIFT) && (count == LAST);
   assign busy     = (state == SHIFT);

   full_adder u_fa (
      .a    (a_sr[0]),
      .b    (fa_b),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_c)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state logic: start is only looked at in IDLE.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = SHIFT;
         SHIFT:   if (last_bit) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Serial datapath: capture, shift one bit per clock, publish on last bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr  <= '0;
         b_sr  <= '0;
         r_sr  <= '0;
         count <= '0;
         carry <= 1'b0;
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         D     <= '0;
         Bout  <= 1'b0;
         V     <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
               a_sr  <= A;
               b_sr  <= B;
               a_msb <= A[WIDTH-1];
               b_msb <= B[WIDTH-1];
               carry <= sub_in;
               count <= '0;
            end
         end else begin
            a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
            r_sr  <= result[WIDTH-1:1];
            carry <= fa_c;
            count <= count + 1'b1;
            if (last_bit) begin
               D    <= result;
               Bout <= fa_c ^ sub_q;
               V    <= overflow(a_msb, b_msb, fa_s, sub_q);
               done <= 1'b1;
            end
         end
      end
   end

endmodule
